// File: rtl/ysyx_23060278_pkg.sv
// Shared constants and types for the ysyx_23060278 core: IFU state encoding,
// fetch error codes and the canonical NOP instruction.
package ysyx_23060278_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'b00,
        IFU_AR   = 2'b01,
        IFU_R    = 2'b10,
        IFU_HOLD = 2'b11
    } ifu_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_BUS      = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } ifu_err_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_23060278_ifu_timer.sv
// Bus-phase watchdog: counts cycles while enabled and flags the last allowed
// cycle so the owner can abort on the same edge.
module ysyx_23060278_ifu_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // design samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + W'(1);
        end
    end

    // Asserted during the TIMEOUT-th enabled cycle, so exactly TIMEOUT cycles elapse.
    assign expired = enable && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_23060278_ifu.sv
// Instruction fetch unit: issues one AXI-lite style read per fetch, holds the
// result (or an error substitute NOP) until the core consumes it.
module ysyx_23060278_ifu
    import ysyx_23060278_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_en,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_err,
    output logic [1:0]  err_code,
    output logic [31:0] fetch_cnt,
    output logic        mem_arvalid,
    output logic [31:0] mem_araddr,
    input  logic        mem_arready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    output logic        mem_rready
);

    ifu_state_e state;
    logic       timer_clear;
    logic       timer_enable;
    logic       timer_expired;
    logic       pc_aligned;

    assign pc_aligned   = (pc[1:0] == 2'b00);
    // Holding the timer clear outside bus phases guarantees it starts from zero.
    assign timer_clear  = (state == IFU_IDLE) || (state == IFU_HOLD) ||
                          ((state == IFU_AR) && mem_arready);
    assign timer_enable = (state == IFU_AR) || (state == IFU_R);

    ysyx_23060278_ifu_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IFU_IDLE;
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b0;
            mem_araddr  <= '0;
            inst_valid  <= 1'b0;
            inst        <= NOP_INST;
            fetch_err   <= 1'b0;
            err_code    <= ERR_NONE;
            fetch_cnt   <= '0;
        end else begin
            case (state)
                IFU_IDLE: begin
                    if (fetch_en && pc_aligned) begin
                        mem_araddr  <= pc;
                        mem_arvalid <= 1'b1;
                        state       <= IFU_AR;
                    end else if (fetch_en) begin
                        inst       <= NOP_INST;
                        fetch_err  <= 1'b1;
                        err_code   <= ERR_MISALIGN;
                        inst_valid <= 1'b1;
                        state      <= IFU_HOLD;
                    end
                end
                IFU_AR: begin
                    if (mem_arready) begin
                        mem_arvalid <= 1'b0;
                        mem_rready  <= 1'b1;
                        state       <= IFU_R;
                    end else if (timer_expired) begin
                        mem_arvalid <= 1'b0;
                        inst        <= NOP_INST;
                        fetch_err   <= 1'b1;
                        err_code    <= ERR_TIMEOUT;
                        inst_valid  <= 1'b1;
                        state       <= IFU_HOLD;
                    end
                end
                IFU_R: begin
                    if (mem_rvalid) begin
                        mem_rready <= 1'b0;
                        inst_valid <= 1'b1;
                        state      <= IFU_HOLD;
                        if (mem_rresp == RESP_OKAY) begin
                            inst      <= mem_rdata;
                            fetch_err <= 1'b0;
                            err_code  <= ERR_NONE;
                            fetch_cnt <= fetch_cnt + 32'd1;
                        end else begin
                            inst      <= NOP_INST;
                            fetch_err <= 1'b1;
                            err_code  <= ERR_BUS;
                        end
                    end else if (timer_expired) begin
                        mem_rready <= 1'b0;
                        inst       <= NOP_INST;
                        fetch_err  <= 1'b1;
                        err_code   <= ERR_TIMEOUT;
                        inst_valid <= 1'b1;
                        state      <= IFU_HOLD;
                    end
                end
                IFU_HOLD: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        // Back-to-back handoff skips IDLE to save a cycle.
                        if (fetch_en && pc_aligned) begin
                            mem_araddr  <= pc;
                            mem_arvalid <= 1'b1;
                            state       <= IFU_AR;
                        end else begin
                            state <= IFU_IDLE;
                        end
                    end
                end
                default: state <= IFU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060278_ifu.sv
// Directed bench for ysyx_23060278_ifu: normal fetch, AR stall, misalignment,
// bus error, timeout, HOLD backpressure with back-to-back handoff, reset mid-read.
module tb_ysyx_23060278_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_en;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        fetch_err;
    logic [1:0]  err_code;
    logic [31:0] fetch_cnt;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_23060278_ifu dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .fetch_err   (fetch_err),
        .err_code    (err_code),
        .fetch_cnt   (fetch_cnt),
        .mem_arvalid (mem_arvalid),
        .mem_araddr  (mem_araddr),
        .mem_arready (mem_arready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .mem_rresp   (mem_rresp),
        .mem_rready  (mem_rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] e_inst,
                                 input logic e_valid, input logic e_err,
                                 input logic [1:0] e_code, input logic [31:0] e_cnt);
        check({tag, ".inst"},       inst,       e_inst);
        check({tag, ".inst_valid"}, inst_valid, 32'(e_valid));
        check({tag, ".fetch_err"},  fetch_err,  32'(e_err));
        check({tag, ".err_code"},   err_code,   32'(e_code));
        check({tag, ".fetch_cnt"},  fetch_cnt,  e_cnt);
    endtask

    task automatic consume();
        inst_ready = 1'b1;
        tick();
        check("consume.inst_valid", inst_valid, 32'd0);
        inst_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc = '0; fetch_en = 1'b0; inst_ready = 1'b0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = 2'b00;

        // Reset values
        tick(2);
        check_outputs("reset", 32'h0000_0013, 1'b0, 1'b0, 2'b00, 32'd0);
        check("reset.arvalid", mem_arvalid, 32'd0);
        check("reset.rready",  mem_rready,  32'd0);
        check("reset.araddr",  mem_araddr,  32'd0);
        rst = 1'b0;
        tick();

        // Minimum-latency fetch
        pc = 32'h8000_0000; fetch_en = 1'b1; mem_arready = 1'b1;
        tick();
        check("fast.arvalid", mem_arvalid, 32'd1);
        check("fast.araddr",  mem_araddr,  32'h8000_0000);
        check("fast.valid0",  inst_valid,  32'd0);
        fetch_en = 1'b0;
        tick();
        check("fast.arvalid_drop", mem_arvalid, 32'd0);
        check("fast.rready",       mem_rready,  32'd1);
        check("fast.valid1",       inst_valid,  32'd0);
        mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0010_0093; mem_rresp = 2'b00;
        tick();
        check_outputs("fast", 32'h0010_0093, 1'b1, 1'b0, 2'b00, 32'd1);
        check("fast.rready_drop", mem_rready, 32'd0);
        mem_rvalid = 1'b0;
        consume();

        // AR stall for 3 cycles; pc/fetch_en changes must not disturb the request
        pc = 32'h8000_0000; fetch_en = 1'b1;
        tick();
        check("stall.arvalid0", mem_arvalid, 32'd1);
        pc = 32'h8000_0040;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.arvalid", mem_arvalid, 32'd1);
            check("stall.araddr",  mem_araddr,  32'h8000_0000);
        end
        fetch_en = 1'b0; mem_arready = 1'b1;
        tick();
        check("stall.rready",  mem_rready,  32'd1);
        check("stall.arvalid_drop", mem_arvalid, 32'd0);
        mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hABCD_0113;
        tick();
        check_outputs("stall", 32'hABCD_0113, 1'b1, 1'b0, 2'b00, 32'd2);
        mem_rvalid = 1'b0;
        consume();

        // Misaligned pc
        pc = 32'h8000_0002; fetch_en = 1'b1;
        tick();
        check("misal.arvalid", mem_arvalid, 32'd0);
        check_outputs("misal", 32'h0000_0013, 1'b1, 1'b1, 2'b01, 32'd2);
        fetch_en = 1'b0;
        consume();

        // Bus error response
        pc = 32'h8000_0008; fetch_en = 1'b1; mem_arready = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF; mem_rresp = 2'b10;
        tick();
        check_outputs("buserr", 32'h0000_0013, 1'b1, 1'b1, 2'b10, 32'd2);
        mem_rvalid = 1'b0; mem_rresp = 2'b00;
        consume();

        // AR timeout: 255 cycles in AR, then abort
        pc = 32'h8000_000C; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick(254);
        check("tmo.arvalid_before", mem_arvalid, 32'd1);
        check("tmo.valid_before",   inst_valid,  32'd0);
        tick();
        check("tmo.arvalid_after", mem_arvalid, 32'd0);
        check_outputs("tmo", 32'h0000_0013, 1'b1, 1'b1, 2'b11, 32'd2);
        // Late response after abort is ignored
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        check("late.rready", mem_rready, 32'd0);
        check_outputs("late", 32'h0000_0013, 1'b1, 1'b1, 2'b11, 32'd2);
        mem_rvalid = 1'b0;
        consume();

        // HOLD backpressure then back-to-back handoff
        pc = 32'h8000_0010; fetch_en = 1'b1; mem_arready = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0020_8113;
        tick();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_outputs("hold", 32'h0020_8113, 1'b1, 1'b0, 2'b00, 32'd3);
            tick();
        end
        inst_ready = 1'b1; fetch_en = 1'b1; pc = 32'h8000_0004;
        tick();
        check("b2b.arvalid", mem_arvalid, 32'd1);
        check("b2b.araddr",  mem_araddr,  32'h8000_0004);
        check("b2b.valid",   inst_valid,  32'd0);
        inst_ready = 1'b0; fetch_en = 1'b0; mem_arready = 1'b1;
        tick();
        check("b2b.rready", mem_rready, 32'd1);
        mem_arready = 1'b0;

        // Reset in R: immediate, response discarded
        #2 rst = 1'b1;
        #1;
        check("rstR.rready",  mem_rready,  32'd0);
        check("rstR.arvalid", mem_arvalid, 32'd0);
        check_outputs("rstR", 32'h0000_0013, 1'b0, 1'b0, 2'b00, 32'd0);
        #1 rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0030_0193;
        tick();
        check("rstR.late_valid",  inst_valid,  32'd0);
        check("rstR.late_inst",   inst,        32'h0000_0013);
        check("rstR.late_cnt",    fetch_cnt,   32'd0);
        check("rstR.late_rready", mem_rready,  32'd0);
        mem_rvalid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060278_ifu.md
YSYX_23060278_IFU -- requirements
Module: ysyx_23060278_ifu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles in AR or R before abort.
REQ-002 SHALL have parameter NOP_INST, default 32'h00000013, meaning instruction presented on reset/error.
REQ-003 SHALL use one clock and an asynchronous, active-high reset:
  clk  input  1  rising-edge clock
  rst  input  1  asynchronous active-high reset
REQ-004 SHALL provide these core-side ports:
  pc  input  32  fetch address from PC register
  fetch_en  input  1  request fetch of pc
  inst  output  32  fetched instruction to decoder
  inst_valid  output  1  inst is valid
  inst_ready  input  1  core consumes inst this cycle
  fetch_err  output  1  current inst is an error substitute
  err_code  output  2  00 none, 01 misaligned, 10 bus error, 11 timeout
  fetch_cnt  output  32  count of successful fetches
REQ-005 SHALL provide these memory-side ports:
  mem_arvalid  output  1  read request
  mem_araddr  output  32  read address
  mem_arready  input  1  request accepted
  mem_rvalid  input  1  read data valid
  mem_rdata  input  32  read data
  mem_rresp  input  2  00 OKAY, other values error
  mem_rready  output  1  ready for read data

Function
REQ-006 SHALL implement FSM states IDLE, AR, R, HOLD.
REQ-007 In IDLE with fetch_en=1 and pc[1:0]=0, SHALL latch pc into mem_araddr and enter AR.
REQ-008 In IDLE with fetch_en=1 and pc[1:0]!=0, SHALL issue no request; next state HOLD, inst=NOP_INST, fetch_err=1, err_code=01.
REQ-009 In AR: mem_arvalid=1; mem_araddr stable until mem_arvalid&&mem_arready; then enter R.
REQ-010 In R: mem_rready=1; on mem_rvalid, enter HOLD and register mem_rdata into inst if mem_rresp=00; otherwise inst=NOP_INST, fetch_err=1, err_code=10.
REQ-011 mem_arvalid and mem_rready SHALL be registered outputs, asserted only in AR and R respectively.
REQ-012 In HOLD: inst_valid=1; inst, fetch_err and err_code stable until inst_ready=1.
REQ-013 In HOLD with inst_ready=1: inst_valid falls next cycle; next state IDLE, or AR directly if fetch_en=1 and pc aligned in the same cycle (back-to-back).
REQ-014 Minimum latency SHALL be fetch_en (IDLE) at edge N -> mem_arvalid from N+1 -> with arready=1 and rvalid one cycle later, inst_valid at N+3.
REQ-015 A timeout counter SHALL clear on entering AR or R and increment each cycle there; at TIMEOUT, SHALL abort to HOLD with NOP_INST, fetch_err=1, err_code=11.
REQ-016 After a timeout abort, a late mem_rvalid SHALL be ignored (mem_rready=0).
REQ-017 fetch_cnt SHALL increment by 1 on each error-free capture in R and wrap from 32'hFFFFFFFF to 0.
REQ-018 fetch_en outside IDLE/HOLD-handoff SHALL be ignored; pc changes during AR/R SHALL not affect mem_araddr.
REQ-019 mem_arready in the same cycle mem_arvalid first rises SHALL complete the handshake (single-cycle AR).

Reset
REQ-020 On rst=1, SHALL asynchronously enter IDLE with mem_arvalid=0, mem_rready=0, inst_valid=0, inst=NOP_INST, fetch_err=0, err_code=00, fetch_cnt=0, mem_araddr=0, timer=0.
REQ-021 rst mid-transaction SHALL drop mem_arvalid/mem_rready immediately; the in-flight response SHALL be discarded.

Structure
REQ-022 State encoding, NOP_INST value and err_code constants SHALL reside in the shared ysyx_23060278 package/defines file.
REQ-023 The timeout counter SHALL be a sub-module ysyx_23060278_ifu_timer (clear, enable, expired).

Verification
REQ-024 pc=0x80000000, fetch_en=1, arready=1, rvalid next cycle with rdata=0x00100093 -> inst=0x00100093, inst_valid at N+3, fetch_cnt=1.
REQ-025 arready held 0 for 3 cycles -> mem_araddr stays 0x80000000, arvalid stays 1; completion is unchanged otherwise.
REQ-026 pc=0x80000002 -> no arvalid; inst=0x00000013, fetch_err=1, err_code=01.
REQ-027 rresp=2'b10 -> inst=0x00000013, err_code=10, fetch_cnt unchanged; arready never asserted -> err_code=11 after 255 cycles in AR.
REQ-028 inst_ready held 0 for 5 cycles, then 1 with fetch_en=1 and pc=0x80000004 -> inst stable for those cycles, then arvalid next cycle with araddr=0x80000004.
REQ-029 rst pulsed while in R -> outputs at reset values in the same cycle; a later rvalid is ignored; fetch_cnt=0.
